// File: rtl/i2c_cfg_pkg.sv
// Shared types for the camera register-LUT sequencer.
// Optional macro CFG_VERIFY_EN adds the write read-back states.
package i2c_cfg_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PWR,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DLY,
    S_NEXT,
    S_DONE,
    S_ERR
`ifdef CFG_VERIFY_EN
    ,
    S_VRD,
    S_VWAIT
`endif
  } state_e;

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned MAX_AW = 16;
  localparam logic [MAX_AW-1:0] DELAY_MARK = '1;

endpackage

// File: rtl/cfg_delay_timer.sv
// Loadable down-counter shared by power-up wait and delay entries.
// Counts to zero and holds; expired_o is high while the count is zero.
module cfg_delay_timer
  import i2c_cfg_pkg::*;
#(
  parameter int unsigned INIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] val_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_W'(INIT);
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Walks a camera register LUT and issues I2C register transactions.
// Optional macro CFG_VERIFY_EN: read back every write, retry on mismatch.
module i2c_cfg_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int unsigned REG_AW     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned LUT_DEPTH  = 173,
  parameter int unsigned LUT_AW     = 8,
  parameter int unsigned ID_ENTRIES = 2,
  parameter int unsigned PWR_WAIT   = 20000,
  parameter int unsigned DELAY_UNIT = 50000,
  parameter int unsigned RETRY_MAX  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_start,
  output logic [LUT_AW-1:0]        lut_index,
  input  logic [REG_AW+DATA_W-1:0] lut_data,
  output logic                     i2c_req,
  output logic                     i2c_rd,
  output logic [REG_AW-1:0]        i2c_addr,
  output logic [DATA_W-1:0]        i2c_wdata,
  input  logic                     i2c_done,
  input  logic                     i2c_nack,
  input  logic [DATA_W-1:0]        i2c_rdata,
  output logic                     cfg_busy,
  output logic                     cfg_done,
  output logic                     cfg_err,
  output logic [LUT_AW-1:0]        err_index
);

  localparam int unsigned RW = $clog2(RETRY_MAX + 2);

  state_e state_q, state_d;
  logic fph_q, fph_d;
  logic [LUT_AW-1:0] idx_q, idx_d;
  logic [LUT_AW-1:0] eidx_q, eidx_d;
  logic [REG_AW-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [RW-1:0] rty_q, rty_d, rty_inc;
  logic [REG_AW-1:0] lut_addr;
  logic [DATA_W-1:0] lut_wd;
  logic tmr_load, tmr_exp, is_id, retry_ok, vphase;
  logic [CNT_W-1:0] tmr_val;

  assign {lut_addr, lut_wd} = lut_data;
  assign is_id    = (32'(idx_q) < ID_ENTRIES);
  assign rty_inc  = rty_q + 1'b1;
  assign retry_ok = (32'(rty_inc) <= RETRY_MAX);

  cfg_delay_timer #(.INIT(PWR_WAIT)) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (tmr_load),
    .val_i    (tmr_val),
    .expired_o(tmr_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_PWR;
      fph_q   <= 1'b0;
      idx_q   <= '0;
      eidx_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rty_q   <= '0;
    end else begin
      state_q <= state_d;
      fph_q   <= fph_d;
      idx_q   <= idx_d;
      eidx_q  <= eidx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rty_q   <= rty_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fph_d    = fph_q;
    idx_d    = idx_q;
    eidx_d   = eidx_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rty_d    = rty_q;
    tmr_load = 1'b0;
    tmr_val  = CNT_W'(PWR_WAIT);
    unique case (state_q)
      S_PWR: if (tmr_exp) begin
        state_d = S_FETCH;
        fph_d   = 1'b0;
      end
      // Two cycles so the LUT may be a registered ROM.
      S_FETCH: begin
        fph_d = 1'b1;
        if (fph_q) begin
          fph_d  = 1'b0;
          addr_d = lut_addr;
          data_d = lut_wd;
          if (lut_addr == DELAY_MARK[REG_AW-1:0]) begin
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(lut_wd) * CNT_W'(DELAY_UNIT);
            state_d  = S_DLY;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: if (i2c_done) begin
        if (i2c_nack) begin
          rty_d   = rty_inc;
          state_d = retry_ok ? S_ISSUE : S_ERR;
        end else if (is_id && (i2c_rdata != data_q)) begin
          state_d = S_ERR;
        end else begin
`ifdef CFG_VERIFY_EN
          state_d = is_id ? S_NEXT : S_VRD;
`else
          state_d = S_NEXT;
`endif
        end
      end
`ifdef CFG_VERIFY_EN
      S_VRD: state_d = S_VWAIT;
      S_VWAIT: if (i2c_done) begin
        if (i2c_nack || (i2c_rdata != data_q)) begin
          rty_d   = rty_inc;
          state_d = retry_ok ? S_ISSUE : S_ERR;
        end else begin
          state_d = S_NEXT;
        end
      end
`endif
      S_DLY: if (tmr_exp) state_d = S_NEXT;
      S_NEXT: begin
        rty_d = '0;
        if (idx_q == LUT_AW'(LUT_DEPTH - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_IDLE, S_DONE, S_ERR: if (cfg_start) begin
        state_d  = S_PWR;
        fph_d    = 1'b0;
        idx_d    = '0;
        eidx_d   = '0;
        rty_d    = '0;
        tmr_load = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if ((state_d == S_ERR) && (state_q != S_ERR)) eidx_d = idx_q;
  end

`ifdef CFG_VERIFY_EN
  assign vphase  = (state_q == S_VWAIT);
  assign i2c_req = (state_q == S_WAIT) || vphase;
`else
  assign vphase  = 1'b0;
  assign i2c_req = (state_q == S_WAIT);
`endif

  assign i2c_rd    = i2c_req & (is_id | vphase);
  assign i2c_addr  = addr_q;
  assign i2c_wdata = data_q;
  assign lut_index = idx_q;
  assign err_index = eidx_q;
  assign cfg_done  = (state_q == S_DONE);
  assign cfg_err   = (state_q == S_ERR);
  assign cfg_busy  = !((state_q == S_IDLE) || cfg_done || cfg_err);

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Scoreboard bench: I2C slave model plus registered LUT model.
// Build with +define+CFG_VERIFY_EN to cover the read-back path.
module tb_i2c_cfg_sequencer;

  typedef struct {
    logic       rd;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] i;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start;
  logic [7:0]  lut_index;
  logic [15:0] lut_data = '0;
  logic        i2c_req, i2c_rd;
  logic [7:0]  i2c_addr, i2c_wdata;
  logic        i2c_done, i2c_nack;
  logic [7:0]  i2c_rdata;
  logic        cfg_busy, cfg_done, cfg_err;
  logic [7:0]  err_index;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int nobs = 0;
  int vb_idx = -1;
  int bad_left = 0;
  logic [15:0] lut [8];
  logic [7:0]  mem [256];
  int  nack_left [256];
  bit  seen [256];
  int  t_first [256];
  txn_t exp_q [$];

  i2c_cfg_sequencer #(
    .REG_AW(8), .DATA_W(8), .LUT_DEPTH(8), .LUT_AW(8),
    .ID_ENTRIES(2), .PWR_WAIT(10), .DELAY_UNIT(4), .RETRY_MAX(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
    .lut_index(lut_index), .lut_data(lut_data),
    .i2c_req(i2c_req), .i2c_rd(i2c_rd), .i2c_addr(i2c_addr),
    .i2c_wdata(i2c_wdata), .i2c_done(i2c_done), .i2c_nack(i2c_nack),
    .i2c_rdata(i2c_rdata), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .cfg_err(cfg_err), .err_index(err_index)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    lut_data <= (lut_index < 8) ? lut[lut_index[2:0]] : 16'h0;
  end

  // Slave model: logs each request against the scoreboard, answers 2 cycles later.
  initial begin : slave
    txn_t e;
    logic nk;
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
    i2c_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (i2c_req === 1'b1 && rst_n === 1'b1) begin
        if (!seen[lut_index]) begin
          seen[lut_index] = 1'b1;
          t_first[lut_index] = cyc;
        end
        nobs++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL txn: unexpected req idx=%0d rd=%0b addr=%h", lut_index, i2c_rd, i2c_addr);
        end else begin
          e = exp_q.pop_front();
          if (i2c_rd !== e.rd || i2c_addr !== e.a || lut_index !== e.i || (!e.rd && i2c_wdata !== e.d)) begin
            fails++;
            $display("FAIL txn: got idx=%0d rd=%0b addr=%h wd=%h, required idx=%0d rd=%0b addr=%h wd=%h",
                     lut_index, i2c_rd, i2c_addr, i2c_wdata, e.i, e.rd, e.a, e.d);
          end
        end
        repeat (2) @(posedge clk);
        #1;
        nk = (nack_left[lut_index] > 0);
        if (nk) nack_left[lut_index]--;
        i2c_rdata = i2c_rd ? mem[i2c_addr] : 8'h00;
        if (i2c_rd && !nk && bad_left > 0 && lut_index >= 2) begin
          i2c_rdata = 8'h00;
          bad_left--;
        end
        if (!i2c_rd && !nk) mem[i2c_addr] = i2c_wdata;
        i2c_nack = nk;
        i2c_done = 1'b1;
        @(posedge clk); #1;
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
      end
    end
  end

  task automatic push_entry(input int i, input int nacks, input int vbad, input bit ok);
    txn_t t;
    txn_t r;
    t.rd = (i < 2);
    t.a = lut[i][15:8];
    t.d = lut[i][7:0];
    t.i = 8'(i);
    r = t;
    r.rd = 1'b1;
    if (t.a == 8'hFF) return;
    repeat (nacks) exp_q.push_back(t);
    if (!ok) return;
`ifdef CFG_VERIFY_EN
    if (!t.rd) begin
      repeat (vbad + 1) begin
        exp_q.push_back(t);
        exp_q.push_back(r);
      end
      return;
    end
`endif
    if (vbad < 0) return;
    exp_q.push_back(t);
  endtask

  task automatic push_run(input int ni, input int nn, input bit nok);
    for (int i = 0; i < 8; i++) begin
      push_entry(i, (i == ni) ? nn : 0, (i == vb_idx) ? 1 : 0, (i != ni) || nok);
      if (i == ni && !nok) break;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) cfg_start = 1'b1;
    @(negedge clk) cfg_start = 1'b0;
  endtask

  task automatic wait_end(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (cfg_done || cfg_err) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst_n = 1'b0;
    cfg_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (i2c_req !== 1'b0 || i2c_rd !== 1'b0) begin
      fails++; $display("FAIL reset_req: req=%b rd=%b, required 0 0", i2c_req, i2c_rd);
    end
    tests++;
    if (cfg_done !== 1'b0 || cfg_err !== 1'b0) begin
      fails++; $display("FAIL reset_flags: done=%b err=%b, required 0 0", cfg_done, cfg_err);
    end
    tests++;
    if (lut_index !== 8'd0 || err_index !== 8'd0) begin
      fails++; $display("FAIL reset_idx: idx=%0d eidx=%0d, required 0 0", lut_index, err_index);
    end
    tests++;
    if (i2c_addr !== 8'h00 || i2c_wdata !== 8'h00) begin
      fails++; $display("FAIL reset_bus: addr=%h wd=%h, required 00 00", i2c_addr, i2c_wdata);
    end
    push_run(-1, 0, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    wait_end(ok);
    tests++;
    if (!ok || cfg_done !== 1'b1) begin
      fails++; $display("FAIL autostart: done=%b ok=%b, required 1 1", cfg_done, ok);
    end
  endtask

  task automatic test_sequence();
    tests++;
    if (lut_index !== 8'd7 || cfg_err !== 1'b0 || cfg_busy !== 1'b0) begin
      fails++; $display("FAIL done_state: idx=%0d err=%b busy=%b, required 7 0 0", lut_index, cfg_err, cfg_busy);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL seq_left: %0d txns missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_id_mismatch();
    bit ok;
    int n0;
    lut[0] = 16'h1C7F;
    mem[8'h1C] = 8'h7E;
    push_entry(0, 0, 0, 1'b1);
    pulse_start();
    wait_end(ok);
    tests++;
    if (!ok || cfg_err !== 1'b1 || cfg_done !== 1'b0) begin
      fails++; $display("FAIL id_err: err=%b done=%b, required 1 0", cfg_err, cfg_done);
    end
    tests++;
    if (err_index !== 8'd0) begin
      fails++; $display("FAIL id_eidx: %0d, required 0", err_index);
    end
    n0 = nobs;
    repeat (30) @(posedge clk);
    tests++;
    if (nobs != n0 || exp_q.size() != 0) begin
      fails++; $display("FAIL id_quiet: reqs=%0d left=%0d, required %0d 0", nobs, exp_q.size(), n0);
    end
    lut[0] = 16'h0A76;
  endtask

  task automatic test_nack_retry();
    bit ok;
    nack_left[5] = 2;
    push_run(5, 2, 1'b1);
    pulse_start();
    wait_end(ok);
    tests++;
    if (!ok || cfg_done !== 1'b1 || exp_q.size() != 0 || nack_left[5] != 0) begin
      fails++; $display("FAIL nack2: done=%b left=%0d nacks=%0d, required 1 0 0", cfg_done, exp_q.size(), nack_left[5]);
    end
    nack_left[5] = 4;
    push_run(5, 4, 1'b0);
    pulse_start();
    wait_end(ok);
    tests++;
    if (!ok || cfg_err !== 1'b1 || exp_q.size() != 0) begin
      fails++; $display("FAIL nack4: err=%b left=%0d, required 1 0", cfg_err, exp_q.size());
    end
    tests++;
    if (err_index !== 8'd5) begin
      fails++; $display("FAIL nack4_eidx: %0d, required 5", err_index);
    end
    nack_left[5] = 0;
  endtask

  task automatic test_delay();
    bit ok;
    int gn, gd;
    foreach (seen[i]) seen[i] = 1'b0;
    push_run(-1, 0, 1'b1);
    pulse_start();
    wait_end(ok);
    gn = t_first[3] - t_first[2];
    gd = t_first[5] - t_first[3];
    // 3 ticks x 4, plus the delay entry's own 2 fetch, 1 expiry and 1 retire cycles.
    tests++;
    if (!ok || !seen[5] || gd - gn != 16) begin
      fails++; $display("FAIL delay_gap: extra=%0d, required 16", gd - gn);
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    int n0;
    push_run(-1, 0, 1'b1);
    pulse_start();
    n0 = nobs;
    for (int i = 0; i < 500 && nobs < n0 + 2; i++) @(posedge clk);
    tests++;
    if (cfg_busy !== 1'b1) begin
      fails++; $display("FAIL busy_mid: busy=%b, required 1", cfg_busy);
    end
    pulse_start();
    wait_end(ok);
    tests++;
    if (!ok || cfg_done !== 1'b1 || exp_q.size() != 0) begin
      fails++; $display("FAIL start_busy: done=%b left=%0d, required 1 0", cfg_done, exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    push_run(-1, 0, 1'b1);
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (i2c_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++; $display("FAIL rst_wait: req=%b, required 1", i2c_req);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (i2c_req !== 1'b0 || lut_index !== 8'd0) begin
      fails++; $display("FAIL async_rst: req=%b idx=%0d, required 0 0", i2c_req, lut_index);
    end
    repeat (5) @(negedge clk);
    exp_q.delete();
    push_run(-1, 0, 1'b1);
    rst_n = 1'b1;
    wait_end(ok);
    tests++;
    if (!ok || cfg_done !== 1'b1 || exp_q.size() != 0) begin
      fails++; $display("FAIL rst_rerun: done=%b left=%0d, required 1 0", cfg_done, exp_q.size());
    end
  endtask

`ifdef CFG_VERIFY_EN
  task automatic test_verify();
    bit ok;
    lut[2] = 16'h1204;
    vb_idx = 2;
    bad_left = 1;
    push_run(-1, 0, 1'b1);
    pulse_start();
    wait_end(ok);
    tests++;
    if (!ok || cfg_done !== 1'b1 || exp_q.size() != 0 || bad_left != 0) begin
      fails++; $display("FAIL verify: done=%b left=%0d bad=%0d, required 1 0 0", cfg_done, exp_q.size(), bad_left);
    end
    vb_idx = -1;
    lut[2] = 16'h1280;
  endtask
`endif

  initial begin
    lut[0] = 16'h0A76;
    lut[1] = 16'h0B73;
    lut[2] = 16'h1280;
    lut[3] = 16'h1101;
    lut[4] = 16'hFF03;
    lut[5] = 16'h3A04;
    lut[6] = 16'h40D0;
    lut[7] = 16'h8C00;
    foreach (mem[i]) mem[i] = 8'h00;
    foreach (nack_left[i]) nack_left[i] = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    foreach (t_first[i]) t_first[i] = 0;
    mem[8'h0A] = 8'h76;
    mem[8'h0B] = 8'h73;
    test_reset();
    test_sequence();
    test_id_mismatch();
    test_nack_retry();
    test_delay();
    test_start_ignored();
    test_async_reset();
`ifdef CFG_VERIFY_EN
    test_verify();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
